// File: rtl/shift_left_pipe_pkg.sv
// Shared widths and the symbol-granular left-shift helper for the shift_left_pipe datapath.
package shift_left_pipe_pkg;

    localparam int SYM_W        = 5;
    localparam int NSYM         = 10;
    localparam int WORD_W       = SYM_W * NSYM;
    localparam int SHIFT_W      = 3;
    localparam int SHIFT_MAX_OK = 4;
    localparam int ERR_CNT_W    = 8;

    // Symbol k of the result takes symbol k-n of the input; vacated low symbols take fill.
    function automatic logic [WORD_W-1:0] shl_syms(
        input logic [WORD_W-1:0] word,
        input int                n,
        input logic [SYM_W-1:0]  fill
    );
        logic [WORD_W-1:0] res;
        res = '0;
        for (int k = 0; k < NSYM; k++) begin
            if (k >= n) begin
                res[k*SYM_W +: SYM_W] = word[(k-n)*SYM_W +: SYM_W];
            end else begin
                res[k*SYM_W +: SYM_W] = fill;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_left_pipe_stage.sv
// sym_shl_stage: one valid/ready pipeline register that shifts its word left by sel_i*STEP symbols.
module sym_shl_stage
    import shift_left_pipe_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int STEP   = 1,
    parameter int SIDE_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] data_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [SYM_W-1:0]  fill_i,
    input  logic [SIDE_W-1:0] side_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] data_o,
    output logic [SIDE_W-1:0] side_o
);

    logic              load;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [SIDE_W-1:0] side_q, side_d;

    // Load when empty or when the downstream takes the current word this same cycle.
    assign load       = !valid_q || out_ready_i;
    assign in_ready_o = load;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        side_d  = side_q;
        if (load) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = shl_syms(data_i, int'(sel_i) * STEP, fill_i);
                side_d = side_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            side_q  <= '0;
        end else begin
            valid_q <= valid_d;
            side_q  <= side_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign out_valid_o = valid_q;
    assign data_o      = data_q;
    assign side_o      = side_q;

endmodule

// File: rtl/shift_left_pipe.sv
// Two-stage symbol left shifter: stage 1 shifts by shift[1:0], stage 2 adds 4 more when shift[2] is set.
module shift_left_pipe
    import shift_left_pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic [SYM_W-1:0]     fill,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int S1_SIDE_W = SYM_W + 2;

    logic                 shift_err;
    logic                 accept;
    logic                 s1_valid;
    logic                 s2_ready;
    logic [WORD_W-1:0]    s1_data;
    logic [S1_SIDE_W-1:0] s1_side;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    assign shift_err = (shift > SHIFT_W'(SHIFT_MAX_OK));
    assign accept    = in_valid && in_ready;

    // Fill and shift[2] ride along with stage 1 so stage 2 can finish the shift.
    sym_shl_stage #(
        .SEL_W  (2),
        .STEP   (1),
        .SIDE_W (S1_SIDE_W)
    ) u_stage1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (in),
        .sel_i       (shift[1:0]),
        .fill_i      (fill),
        .side_i      ({fill, shift[2], shift_err}),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .data_o      (s1_data),
        .side_o      (s1_side)
    );

    sym_shl_stage #(
        .SEL_W  (1),
        .STEP   (4),
        .SIDE_W (1)
    ) u_stage2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .data_i      (s1_data),
        .sel_i       (s1_side[1]),
        .fill_i      (s1_side[S1_SIDE_W-1:2]),
        .side_i      (s1_side[0]),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (out),
        .side_o      (out_err)
    );

    always_comb begin
        err_count_d = err_count_q;
        if (accept && shift_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_shift_left_pipe.sv
// Scoreboard bench for shift_left_pipe: driver pushes reference results, negedge monitor pops and compares.
module tb_shift_left_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [49:0] in_w = '0;
    logic [2:0]  shift = '0;
    logic [4:0]  fill = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [49:0] out_w;
    logic        out_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    shift_left_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_w),
        .shift     (shift),
        .fill      (fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_w),
        .out_err   (out_err),
        .err_count (err_count)
    );

    typedef struct {
        logic [49:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_out = 0;
    int          err_model = 0;
    logic [49:0] last_out = '0;
    logic        stalled = 1'b0;
    logic [49:0] held_data = '0;
    logic        held_err = 1'b0;

    // Whole-word view: shifting left by s symbols is a multiply by 32**s, then fill the low symbols.
    function automatic logic [49:0] ref_shift(input logic [49:0] w, input int s, input logic [4:0] f);
        logic [99:0] wide;
        logic [49:0] fills;
        fills = '0;
        for (int i = 0; i < s; i++) fills = (fills << 5) | 50'(f);
        wide = ({50'b0, w} << (5 * s)) | {50'b0, fills};
        return wide[49:0];
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk(out_valid === 1'b1, "stall_valid", 64'(out_valid), 64'd1);
                    chk(out_w === held_data, "stall_data", 64'(out_w), 64'(held_data));
                    chk(out_err === held_err, "stall_err", 64'(out_err), 64'(held_err));
                end
                if (out_valid === 1'b1 && out_ready) begin
                    chk(sb.size() != 0, "unexpected_out", 64'(out_w), 64'd0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk(out_w === e.data, "out_data", 64'(out_w), 64'(e.data));
                        chk(out_err === e.err, "out_err", 64'(out_err), 64'(e.err));
                    end
                    n_out++;
                    last_out = out_w;
                end
                stalled   = (out_valid === 1'b1) && !out_ready;
                held_data = out_w;
                held_err  = out_err;
            end
        end
    end

    // One cycle of stimulus; the scoreboard depth is the pipeline occupancy at this point.
    task automatic step(input logic v, input logic [49:0] w, input logic [2:0] s,
                        input logic [4:0] f, input logic ordy, output logic acc);
        logic exp_rdy;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_w      = w;
        shift     = s;
        fill      = f;
        out_ready = ordy;
        #1;
        exp_rdy = !(sb.size() == 2 && !ordy);
        chk(in_ready === exp_rdy, "in_ready", 64'(in_ready), 64'(exp_rdy));
        chk(err_count === 8'(err_model), "err_count", 64'(err_count), 64'(err_model));
        acc = v && (in_ready === 1'b1);
        if (acc) begin
            sb.push_back('{ref_shift(w, int'(s), f), (s > 3'd4)});
            if (s > 3'd4 && err_model < 255) err_model++;
        end
    endtask

    // mode: 0 = out_ready low, 1 = out_ready high, 2 = random per cycle
    task automatic send(input logic [49:0] w, input logic [2:0] s, input logic [4:0] f, input int mode);
        logic acc;
        logic ordy;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            ordy = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
            step(1'b1, w, s, f, ordy, acc);
            tries++;
        end
        chk(acc, "send_timeout", 64'(tries), 64'd100);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, ordy, acc);
    endtask

    task automatic drain();
        logic acc;
        int   t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            step(1'b0, '0, '0, '0, 1'b1, acc);
            t++;
        end
        chk(sb.size() == 0, "drain_timeout", 64'(sb.size()), 64'd0);
        step(1'b0, '0, '0, '0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        err_model = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk(out_valid === 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(err_count === 8'd0, "rst_err_count", 64'(err_count), 64'd0);
        chk(in_ready === 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [49:0] rand_word();
        logic [49:0] w;
        w = {18'($urandom), $urandom};
        return w;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [49:0] w19;
        logic [49:0] exp19;
        logic [49:0] wa;
        logic [49:0] wb;
        logic [49:0] wc;
        logic        acc;
        int          n0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk(out_valid === 1'b0, "init_out_valid", 64'(out_valid), 64'd0);
        chk(err_count === 8'd0, "init_err_count", 64'(err_count), 64'd0);
        chk(in_ready === 1'b1, "init_in_ready", 64'(in_ready), 64'd1);

        // Directed word: symbols 0..9 hold 1..10, shift 2, fill 1F.
        for (int k = 0; k < 10; k++) w19[k*5 +: 5] = 5'(k + 1);
        exp19 = '0;
        for (int k = 0; k < 10; k++) exp19[k*5 +: 5] = (k < 2) ? 5'h1F : 5'(k - 1);
        send(w19, 3'd2, 5'h1F, 1);
        idle(1, 1'b1);
        chk(out_valid === 1'b0, "latency_cycle1", 64'(out_valid), 64'd0);
        idle(1, 1'b1);
        chk(out_valid === 1'b1, "latency_cycle2", 64'(out_valid), 64'd1);
        chk(out_err === 1'b0, "directed_err", 64'(out_err), 64'd0);
        idle(1, 1'b1);
        chk(last_out === exp19, "directed_data", 64'(last_out), 64'(exp19));
        drain();

        // Shift sweep 0..7 on the same word.
        do_reset();
        for (int s = 0; s < 8; s++) send(w19, 3'(s), 5'h1F, 1);
        drain();
        chk(err_count === 8'd3, "sweep_err_count", 64'(err_count), 64'd3);

        // 20 back-to-back random words under random backpressure.
        n0 = n_out;
        for (int i = 0; i < 20; i++) send(rand_word(), 3'($urandom_range(0, 7)), 5'($urandom), 2);
        drain();
        chk(n_out - n0 == 20, "stream_count", 64'(n_out - n0), 64'd20);

        // Stalled output: two words fit, the third waits until out_ready rises.
        do_reset();
        wa = rand_word();
        wb = rand_word();
        wc = rand_word();
        send(wa, 3'd1, 5'h03, 0);
        send(wb, 3'd5, 5'h0C, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, wc, 3'd3, 5'h11, 1'b0, acc);
            chk(acc == 1'b0, "third_blocked", 64'(acc), 64'd0);
        end
        send(wc, 3'd3, 5'h11, 1);
        drain();

        // err_count saturation.
        do_reset();
        for (int i = 0; i < 300; i++) send(rand_word(), 3'd7, 5'($urandom), 1);
        drain();
        chk(err_count === 8'd255, "err_saturate", 64'(err_count), 64'd255);
        idle(3, 1'b1);
        chk(err_count === 8'd255, "err_hold", 64'(err_count), 64'd255);

        // Reset with both stages full discards the in-flight words.
        do_reset();
        send(rand_word(), 3'd6, 5'h0A, 0);
        send(rand_word(), 3'd7, 5'h15, 0);
        idle(1, 1'b0);
        chk(in_ready === 1'b0, "full_in_ready", 64'(in_ready), 64'd0);
        do_reset();
        idle(4, 1'b1);
        chk(n_out >= 0 && sb.size() == 0, "post_rst_empty", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 3; i++) send(rand_word(), 3'($urandom_range(0, 7)), 5'($urandom), 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
